// File: rtl/data_cache_controller.sv
// data_cache_controller
//   Direct-mapped, write-back, write-allocate L1 data cache sitting between
//   the CPU MEM stage and a block-oriented data memory.
//
//   Ports
//     CLK, RESET          clock; asynchronous active-low reset
//     cpu_read/cpu_write  word request from the pipeline (write wins if both)
//     cpu_address         byte address: [3:2] word, [3+IDX_W:4] index, rest tag
//     cpu_writedata       store word
//     cpu_readdata        load word, combinational on a read hit, else 0
//     busywait            pipeline stall while the access is outstanding
//     mem_read/mem_write  block fetch / block write-back request
//     mem_address         block address (byte address [31:4])
//     mem_writedata       victim block during write-back (word0 in [31:0])
//     mem_readdata        fetched block, valid when mem_busywait is low
//     mem_busywait        memory busy
module data_cache_controller #(
  parameter int NUM_SETS = 8,
  parameter int IDX_W    = 3
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         cpu_read,
  input  logic         cpu_write,
  input  logic [31:0]  cpu_address,
  input  logic [31:0]  cpu_writedata,
  output logic [31:0]  cpu_readdata,
  output logic         busywait,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_address,
  output logic [127:0] mem_writedata,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FETCH} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_first;      // high during the first cycle of a memory state
  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  logic [127:0]        r_data [NUM_SETS];

  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [1:0]          w_off;
  logic                w_req;
  logic                w_hit;
  logic                w_mem_done;
  logic                w_wr_hit;
  logic                w_fill;
  logic                w_wb_done;
  logic                w_unused_bits;

  assign w_idx         = cpu_address[3+IDX_W:4];
  assign w_tag         = cpu_address[31:4+IDX_W];
  assign w_off         = cpu_address[3:2];
  assign w_unused_bits = ^cpu_address[1:0];
  assign w_req         = cpu_read | cpu_write;
  assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // Memory busywait is ignored in the first cycle of a transfer so that a
  // memory which raises busywait one cycle late is not mistaken for done.
  assign w_mem_done    = !mem_busywait && !r_first;
  assign w_wr_hit      = (r_state == S_IDLE) && cpu_write && w_hit;
  assign w_fill        = (r_state == S_FETCH) && w_mem_done;
  assign w_wb_done     = (r_state == S_WRITEBACK) && w_mem_done;

  // The victim is always the line at the current index.
  assign mem_writedata = r_data[w_idx];

  always_comb begin
    w_next       = r_state;
    busywait     = 1'b1;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_address  = cpu_address[31:4];
    cpu_readdata = 32'h0;
    case (r_state)
      S_IDLE: begin
        busywait = w_req && !w_hit;
        if (w_req && !w_hit)
          w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_FETCH;
        // A simultaneous read+write is a write, so it returns no data.
        if (cpu_read && !cpu_write && w_hit)
          cpu_readdata = r_data[w_idx][{w_off, 5'b0} +: 32];
      end
      S_WRITEBACK: begin
        mem_write   = 1'b1;
        mem_address = {r_tag[w_idx], w_idx};
        if (w_mem_done) w_next = S_FETCH;
      end
      S_FETCH: begin
        mem_read = 1'b1;
        if (w_mem_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_first <= 1'b0;
    end else begin
      r_state <= w_next;
      r_first <= (w_next != r_state);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_fill) begin
      r_valid[w_idx] <= 1'b1;
      r_dirty[w_idx] <= 1'b0;
    end else if (w_wb_done) begin
      r_dirty[w_idx] <= 1'b0;
    end else if (w_wr_hit) begin
      r_dirty[w_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the cleared valid bits mask them.
  // A write miss lands here as a write hit in the IDLE cycle after the fill.
  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_data[w_idx] <= mem_readdata;
      r_tag[w_idx]  <= w_tag;
    end else if (w_wr_hit) begin
      r_data[w_idx][{w_off, 5'b0} +: 32] <= cpu_writedata;
    end
  end

endmodule
